uart_periph: RTL

Memory-mapped 8N1 UART on the CPU native memory bus, attached as one more device slot of the address decoder, decoded at 0x400001xx next to the debug LEDs. Transmit bytes pass through a small FIFO into a shift register. An optional receiver deserialises `uart_rx` into a one-byte holding register. All registers are 32-bit words; only the low bits are significant.

---
 rtl/uart_periph_pkg.sv | 40 ++++
 rtl/uart_tx_fifo.sv | 48 ++++
 rtl/uart_periph.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_periph_pkg.sv
// rtl/uart_periph_pkg.sv - register map, status bit indices, FSM state types and divisor helper for uart_periph.
package uart_periph_pkg;

  localparam int DIV_W = 16;

  localparam logic [5:0] REG_DATA    = 6'd0;
  localparam logic [5:0] REG_STATUS  = 6'd1;
  localparam logic [5:0] REG_DIVISOR = 6'd2;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_IDLE    = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // A programmed divisor of zero behaves as one clock per bit.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO with extra-MSB pointers; a pop frees a slot for a same-cycle push.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_periph.sv
// rtl/uart_periph.sv - memory-mapped 8N1 UART: bus slave, TX FIFO and serialiser.
// The receiver and its status bits exist only when UART_PERIPH_RX_EN is defined.
module uart_periph
  import uart_periph_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int CLK_DIV  = 208
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [5:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  input  logic        uart_rx
);

  bus_state_e       bus_state_q, bus_state_d;
  logic [DIV_W-1:0] div_q, div_d, div_m1;
  logic             acc, is_write, wr_acc, rd_acc, data_push_req;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;

  tx_state_e        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d, tx_tick, tx_idle;

  logic [7:0]       rx_byte;
  logic             rx_valid, rx_overrun, frame_err;
  logic [4:0]       status;
  logic [31:0]      rdata;
  logic             unused_ok;

  assign acc           = (bus_state_q == BUS_ACK);
  assign is_write      = |mem_wstrb;
  assign wr_acc        = acc && is_write;
  assign rd_acc        = acc && !is_write;
  assign data_push_req = mem_valid && (mem_addr == REG_DATA) && mem_wstrb[0];
  assign fifo_push     = wr_acc && (mem_addr == REG_DATA) && mem_wstrb[0];
  assign div_m1        = eff_div(div_q) - DIV_W'(1);
  assign mem_ready     = acc;
  assign mem_rdata     = rdata;
  assign uart_tx       = tx_q;
  assign unused_ok     = ^{mem_wdata[31:16], mem_wstrb[3:2], uart_rx};

  uart_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (fifo_push),
    .push_data (mem_wdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A DATA write to a full FIFO is held in IDLE, so the push in ACK always has room.
  always_comb begin
    bus_state_d = bus_state_q;
    case (bus_state_q)
      BUS_IDLE: if (mem_valid && !(data_push_req && fifo_full)) bus_state_d = BUS_ACK;
      BUS_ACK:  bus_state_d = BUS_IDLE;
      default:  bus_state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q;
    if (wr_acc && (mem_addr == REG_DIVISOR)) begin
      if (mem_wstrb[0]) div_d[7:0]  = mem_wdata[7:0];
      if (mem_wstrb[1]) div_d[15:8] = mem_wdata[15:8];
    end
  end

  assign tx_idle = fifo_empty && (tx_state_q == TX_IDLE);

  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = fifo_full;
    status[ST_TX_IDLE]    = tx_idle;
    status[ST_RX_VALID]   = rx_valid;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_FRAME_ERR]  = frame_err;
  end

  always_comb begin
    rdata = '0;
    if (rd_acc) begin
      case (mem_addr)
        REG_DATA:    rdata = {24'h0, rx_byte};
        REG_STATUS:  rdata = {27'h0, status};
        REG_DIVISOR: rdata = {16'h0, div_q};
        default:     rdata = '0;
      endcase
    end
  end

  assign tx_tick = (tx_cnt_q == '0);

  // STOP chains straight into the next START when bytes are waiting.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_state_d = TX_START;
          tx_cnt_d   = div_m1;
          tx_shift_d = fifo_rdata;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = div_m1;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_cnt_d = div_m1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_state_d = TX_START;
            tx_cnt_d   = div_m1;
            tx_shift_d = fifo_rdata;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus_state_q <= BUS_IDLE;
      div_q       <= DIV_W'(CLK_DIV);
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
    end else begin
      bus_state_q <= bus_state_d;
      div_q       <= div_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
    end
  end

`ifdef UART_PERIPH_RX_EN
  rx_state_e        rx_state_q, rx_state_d;
  logic [1:0]       rx_sync_q, rx_sync_d;
  logic             rx_prev_q, rx_prev_d, rx_s, rx_tick, rx_read, rx_w1c, rx_good, rx_bad;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_half, rx_half_m1;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, frame_err_q, frame_err_d;

  assign rx_s       = rx_sync_q[1];
  assign rx_tick    = (rx_cnt_q == '0);
  assign rx_half    = eff_div(div_q) >> 1;
  assign rx_half_m1 = (rx_half == '0) ? '0 : rx_half - DIV_W'(1);
  assign rx_read    = rd_acc && (mem_addr == REG_DATA);
  assign rx_w1c     = wr_acc && (mem_addr == REG_STATUS) && mem_wstrb[0];
  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign frame_err  = frame_err_q;

  always_comb begin
    rx_sync_d  = {rx_sync_q[0], uart_rx};
    rx_prev_d  = rx_s;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_good    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = rx_half_m1;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
          rx_cnt_d   = div_m1;
          rx_bit_d   = '0;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_cnt_d   = div_m1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_state_d = RX_IDLE;
          rx_good    = rx_s;
          rx_bad     = !rx_s;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // A read racing a new byte returns the old byte and does not count as overrun.
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    frame_err_d  = frame_err_q;
    if (rx_read) rx_valid_d = 1'b0;
    if (rx_w1c && mem_wdata[ST_RX_OVERRUN]) rx_overrun_d = 1'b0;
    if (rx_w1c && mem_wdata[ST_FRAME_ERR])  frame_err_d  = 1'b0;
    if (rx_good) begin
      rx_byte_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_read) rx_overrun_d = 1'b1;
    end
    if (rx_bad) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_state_q   <= RX_IDLE;
      rx_sync_q    <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end
`else
  assign rx_byte    = '0;
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign frame_err  = 1'b0;
`endif

endmodule
